// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
// Contents:
//   XLEN       data width of the register file
//   REG_IDX_W  register index width
//   REG_ZERO   index of the hard-wired zero register
//   wb_entry_t one pending register write (destination and data)
package regfile_sched_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/sched_result_fifo.sv
// Small FIFO that holds MDU results while the pipeline writeback stage owns
// the register-file write port.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i         enqueue push_data_i (ignored when full)
//   push_data_i    entry to enqueue
//   pop_i          dequeue the head entry (ignored when empty)
//   head_o         oldest entry, valid while empty_o is low
//   full_o         no free entry
//   empty_o        no stored entry
module sched_result_fifo
   import regfile_sched_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  wb_entry_t push_data_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int AW = $clog2(BUF_DEPTH);

   // Pointers carry one extra wrap bit so full and empty can be told apart
   // when the index bits are equal.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   wb_entry_t   mem_q [BUF_DEPTH];

   logic do_push;
   logic do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries
   // are meaningful, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Owns the single write port of the 32x32 register file. The in-order
// writeback stage always wins the port; MDU results go straight through
// when the port is free and are buffered otherwise. A per-register
// scoreboard of outstanding MDU destinations stalls decode on RAW/WAW
// hazards, and a counter caps the number of MDU ops in flight.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid, id_rs1, id_rs2,      decode-stage instruction and operand use
//   id_uses_rs1, id_uses_rs2,
//   id_rd, id_long
//   id_stall                       hold decode this cycle
//   wb_valid, wb_rd, wb_data       pipeline writeback request
//   mdu_valid, mdu_rd, mdu_data    MDU result offer
//   mdu_ready                      MDU result accepted this cycle
//   rf_we, rf_rd, rf_wdata         register-file write port
module regfile_wb_scheduler
   import regfile_sched_pkg::*;
#(
   parameter int NREG      = 32,
   parameter int BUF_DEPTH = 2,
   parameter int MAX_LONG  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [REG_IDX_W-1:0] id_rd,
   input  logic                 id_long,
   output logic                 id_stall,
   input  logic                 wb_valid,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 mdu_valid,
   input  logic [REG_IDX_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]      mdu_data,
   output logic                 mdu_ready,
   output logic                 rf_we,
   output logic [REG_IDX_W-1:0] rf_rd,
   output logic [XLEN-1:0]      rf_wdata
);

   localparam int CNT_W = $clog2(MAX_LONG + 1);

   logic [NREG-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] long_cnt_q, long_cnt_d;

   wb_entry_t fifo_head;
   wb_entry_t fifo_in;
   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_push;
   logic      fifo_pop;

   logic                 mdu_direct;  // MDU result takes the port this cycle
   logic                 mdu_wr;      // an MDU result retires (buffered or direct)
   logic [REG_IDX_W-1:0] mdu_wr_rd;
   logic                 issue_long;

   // ---------------------------------------------------------------------
   // Hazard check: purely from registered state, so a scoreboard clear on
   // this edge only unblocks decode on the next cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      id_stall = 1'b0;
      if (id_valid) begin
         id_stall = (id_uses_rs1 & busy_q[id_rs1]) |
                    (id_uses_rs2 & busy_q[id_rs2]) |
                    busy_q[id_rd] |
                    (id_long & (long_cnt_q == CNT_W'(MAX_LONG)));
      end
   end

   assign issue_long = id_valid & ~id_stall & id_long;

   // ---------------------------------------------------------------------
   // Write-port arbitration: WB first, then buffer head, then fall-through.
   // A destination of x0 still consumes its slot but never raises rf_we.
   // Gated by rst so the port is quiet for the whole reset interval.
   // ---------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first, so
   // no path through the branches can leave a value held (latch).
   always_comb begin
      rf_we      = 1'b0;
      rf_rd      = REG_ZERO;
      rf_wdata   = '0;
      fifo_pop   = 1'b0;
      mdu_direct = 1'b0;
      mdu_wr     = 1'b0;
      mdu_wr_rd  = REG_ZERO;
      if (!rst) begin
         if (wb_valid && (wb_rd != REG_ZERO)) begin
            rf_we    = 1'b1;
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
         end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            mdu_wr    = 1'b1;
            mdu_wr_rd = fifo_head.rd;
            if (fifo_head.rd != REG_ZERO) begin
               rf_we    = 1'b1;
               rf_rd    = fifo_head.rd;
               rf_wdata = fifo_head.data;
            end
         end else if (mdu_valid) begin
            mdu_direct = 1'b1;
            mdu_wr     = 1'b1;
            mdu_wr_rd  = mdu_rd;
            if (mdu_rd != REG_ZERO) begin
               rf_we    = 1'b1;
               rf_rd    = mdu_rd;
               rf_wdata = mdu_data;
            end
         end
      end
   end

   // Ready depends only on registered fullness: a pop this cycle does not
   // open a slot for a push in the same cycle.
   assign mdu_ready    = ~fifo_full;
   assign fifo_push    = ~rst & mdu_valid & ~fifo_full & ~mdu_direct;
   assign fifo_in.rd   = mdu_rd;
   assign fifo_in.data = mdu_data;

   sched_result_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_result_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_data_i (fifo_in),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // ---------------------------------------------------------------------
   // Scoreboard and in-flight counter
   // ---------------------------------------------------------------------
   always_comb begin
      busy_d = busy_q;
      if (mdu_wr) busy_d[mdu_wr_rd] = 1'b0;
      if (issue_long && (id_rd != REG_ZERO)) busy_d[id_rd] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;

      long_cnt_d = long_cnt_q;
      case ({issue_long, mdu_wr})
         2'b10:   long_cnt_d = long_cnt_q + 1'b1;
         2'b01:   long_cnt_d = long_cnt_q - 1'b1;
         default: long_cnt_d = long_cnt_q;
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the pre-edge value of its inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         long_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         long_cnt_q <= long_cnt_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler. Inputs change 1 ns after each
// rising edge; outputs are compared 1 ns later, well before the next edge.
module tb_regfile_wb_scheduler;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2, id_long;
   logic        id_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;

   int tests_run    = 0;
   int tests_failed = 0;

   regfile_wb_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rd       (id_rd),
      .id_long     (id_long),
      .id_stall    (id_stall),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .mdu_valid   (mdu_valid),
      .mdu_rd      (mdu_rd),
      .mdu_data    (mdu_data),
      .mdu_ready   (mdu_ready),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_wdata    (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rd = 0; id_long = 0;
      wb_valid = 0; wb_rd = 0; wb_data = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
   endtask

   // Advance past the next rising edge; inputs may then be changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic decode(input logic [4:0] rd, input logic lng,
                         input logic [4:0] rs1, input logic use1);
      id_valid = 1; id_rd = rd; id_long = lng; id_rs1 = rs1; id_uses_rs1 = use1;
      id_rs2 = 0; id_uses_rs2 = 0;
   endtask

   task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb_valid = v; wb_rd = rd; wb_data = d;
   endtask

   task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mdu_valid = v; mdu_rd = rd; mdu_data = d;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      #2;
      check("reset_stall", {31'b0, id_stall}, 0);
      check("reset_ready", {31'b0, mdu_ready}, 1);
      check("reset_we",    {31'b0, rf_we}, 0);
      check("reset_rd",    {27'b0, rf_rd}, 0);
      check("reset_wdata", rf_wdata, 0);
      rst = 0;
      tick();

      // ---------------- RAW hazard on x7 ----------------
      decode(7, 1, 0, 0); #1;
      check("raw_issue_stall", {31'b0, id_stall}, 0);
      tick();
      decode(8, 0, 7, 1); #1;
      check("raw_dep_stall_c1", {31'b0, id_stall}, 1);
      tick(); #1;
      check("raw_dep_stall_c2", {31'b0, id_stall}, 1);
      tick();
      mdu(1, 7, 32'h0000_1234); #1;
      check("raw_mdu_we",    {31'b0, rf_we}, 1);
      check("raw_mdu_rd",    {27'b0, rf_rd}, 7);
      check("raw_mdu_wdata", rf_wdata, 32'h0000_1234);
      check("raw_stall_on_write", {31'b0, id_stall}, 1);
      tick();
      mdu(0, 0, 0); #1;
      check("raw_stall_after", {31'b0, id_stall}, 0);
      tick();
      idle_inputs();

      // ---------------- WB vs MDU conflict ----------------
      decode(9, 1, 0, 0);
      tick();
      idle_inputs();
      wb(1, 3, 32'h0000_AAAA);
      mdu(1, 9, 32'h0000_5555); #1;
      check("conf_wb_rd",    {27'b0, rf_rd}, 3);
      check("conf_wb_wdata", rf_wdata, 32'h0000_AAAA);
      check("conf_ready",    {31'b0, mdu_ready}, 1);
      tick();
      idle_inputs();
      decode(26, 0, 9, 1); #1;
      check("conf_buf_we",    {31'b0, rf_we}, 1);
      check("conf_buf_rd",    {27'b0, rf_rd}, 9);
      check("conf_buf_wdata", rf_wdata, 32'h0000_5555);
      check("conf_stall_x9",  {31'b0, id_stall}, 1);
      tick(); #1;
      check("conf_stall_x9_clear", {31'b0, id_stall}, 0);
      check("conf_idle_we", {31'b0, rf_we}, 0);
      tick();
      idle_inputs();

      // ---------------- Backpressure ----------------
      for (int i = 0; i < 3; i++) begin
         decode(5'(10 + i), 1, 0, 0);
         tick();
      end
      idle_inputs();
      wb(1, 1, 32'h1); mdu(1, 10, 32'hA0); #1;
      check("bp_c1_rd", {27'b0, rf_rd}, 1);
      check("bp_c1_ready", {31'b0, mdu_ready}, 1);
      tick();
      wb(1, 2, 32'h2); mdu(1, 11, 32'hB1); #1;
      check("bp_c2_ready", {31'b0, mdu_ready}, 1);
      tick();
      wb(1, 3, 32'h3); mdu(1, 12, 32'hC2); #1;
      check("bp_c3_ready", {31'b0, mdu_ready}, 0);
      check("bp_c3_rd", {27'b0, rf_rd}, 3);
      tick();
      wb(1, 4, 32'h4); #1;
      check("bp_c4_ready", {31'b0, mdu_ready}, 0);
      check("bp_c4_wdata", rf_wdata, 32'h4);
      tick();
      wb(0, 0, 0); #1;
      check("bp_drain0_rd", {27'b0, rf_rd}, 10);
      check("bp_drain0_wdata", rf_wdata, 32'hA0);
      check("bp_drain0_ready", {31'b0, mdu_ready}, 0);
      tick(); #1;
      check("bp_drain1_rd", {27'b0, rf_rd}, 11);
      check("bp_drain1_wdata", rf_wdata, 32'hB1);
      check("bp_drain1_ready", {31'b0, mdu_ready}, 1);
      tick();
      mdu(0, 0, 0); #1;
      check("bp_drain2_rd", {27'b0, rf_rd}, 12);
      check("bp_drain2_wdata", rf_wdata, 32'hC2);
      tick(); #1;
      check("bp_empty_we", {31'b0, rf_we}, 0);

      // ---------------- Outstanding limit ----------------
      for (int i = 0; i < 4; i++) begin
         decode(5'(13 + i), 1, 0, 0); #1;
         check("lim_issue_stall", {31'b0, id_stall}, 0);
         tick();
      end
      decode(17, 1, 0, 0); #1;
      check("lim_5th_stall", {31'b0, id_stall}, 1);
      decode(18, 0, 1, 1); id_rs2 = 2; id_uses_rs2 = 1; #1;
      check("lim_short_stall", {31'b0, id_stall}, 0);
      tick();
      decode(17, 1, 0, 0);
      mdu(1, 13, 32'hD3); #1;
      check("lim_stall_on_write", {31'b0, id_stall}, 1);
      check("lim_write_rd", {27'b0, rf_rd}, 13);
      tick();
      mdu(0, 0, 0); #1;
      check("lim_5th_issues", {31'b0, id_stall}, 0);
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         mdu(1, 5'(14 + i), 32'(i)); #1;
         check("lim_drain_rd", {27'b0, rf_rd}, 32'(14 + i));
         tick();
      end
      idle_inputs();

      // ---------------- x0 handling ----------------
      decode(0, 1, 0, 0); #1;
      check("x0_issue_stall", {31'b0, id_stall}, 0);
      tick();
      decode(20, 1, 0, 1); #1;
      check("x0_rs1_zero_stall", {31'b0, id_stall}, 0);
      tick();
      idle_inputs();
      wb(1, 5, 32'h55); mdu(1, 20, 32'h2020); #1;
      check("x0_wb_rd", {27'b0, rf_rd}, 5);
      tick();
      wb(1, 0, 32'hDEAD); mdu(1, 0, 32'hBEEF); #1;
      check("x0_wbzero_we", {31'b0, rf_we}, 1);
      check("x0_wbzero_rd", {27'b0, rf_rd}, 20);
      check("x0_wbzero_wdata", rf_wdata, 32'h2020);
      check("x0_wbzero_ready", {31'b0, mdu_ready}, 1);
      tick();
      idle_inputs(); #1;
      check("x0_result_we", {31'b0, rf_we}, 0);
      check("x0_result_rd", {27'b0, rf_rd}, 0);
      tick(); #1;
      check("x0_idle_we", {31'b0, rf_we}, 0);
      // Four fresh long ops must fit if the x0 result released its slot.
      for (int i = 0; i < 4; i++) begin
         decode((i == 0) ? 5'd5 : 5'(20 + i), 1, 0, 0); #1;
         check("x0_cnt_issue_stall", {31'b0, id_stall}, 0);
         tick();
      end
      decode(24, 1, 0, 0); #1;
      check("x0_cnt_full_stall", {31'b0, id_stall}, 1);

      // ---------------- Reset mid-stream ----------------
      idle_inputs();
      wb(1, 1, 32'h1); mdu(1, 21, 32'h21);
      tick();
      idle_inputs();
      decode(25, 0, 5, 1); #1;
      check("rst_pre_stall", {31'b0, id_stall}, 1);
      check("rst_pre_rd", {27'b0, rf_rd}, 21);
      rst = 1; #1;
      check("rst_mid_stall", {31'b0, id_stall}, 0);
      check("rst_mid_we", {31'b0, rf_we}, 0);
      check("rst_mid_ready", {31'b0, mdu_ready}, 1);
      #1 rst = 0;
      tick(); #1;
      check("rst_post_stall", {31'b0, id_stall}, 0);
      check("rst_post_we", {31'b0, rf_we}, 0);
      decode(5, 1, 0, 0); #1;
      check("rst_post_long_stall", {31'b0, id_stall}, 0);
      tick();
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the 32x32 register file (negedge write, async read) between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU).
- Keeps a per-register scoreboard of pending MDU destinations and stalls decode on RAW/WAW hazards against them.
- Sits between ID/WB pipeline stages and registerFile; drives its RegWrite/RD/WriteData.

Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers (index width = 5)
- BUF_DEPTH, 2, MDU result buffer entries (power of 2, >=2)
- MAX_LONG, 4, max outstanding MDU ops (<=15)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2  in  5  decode source registers
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- id_rd  in  5  decode destination
- id_long  in  1  instruction issues to MDU
- id_stall  out  1  hold decode this cycle
- wb_valid  in  1  pipeline writeback request (RegWrite from WB)
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB data
- mdu_valid  in  1  MDU result available
- mdu_rd  in  5  MDU destination
- mdu_data  in  XLEN  MDU result
- mdu_ready  out  1  result accepted when mdu_valid & mdu_ready
- rf_we  out  1  to registerFile RegWrite
- rf_rd  out  5  to registerFile RD
- rf_wdata  out  XLEN  to registerFile WriteData

Behaviour:
- Reset (async, immediate): busy[] all 0, buffer empty (ptrs 0), long_cnt 0. Outputs: id_stall 0, mdu_ready 1, rf_we 0, rf_rd 0, rf_wdata 0. Reset mid-operation discards buffered MDU results; MDU must also be reset.
- Issue fire = id_valid & ~id_stall.
- id_stall (combinational from registered state) = id_valid & (
  (id_uses_rs1 & busy[id_rs1]) | (id_uses_rs2 & busy[id_rs2]) | busy[id_rd] (WAW, any instruction) | (id_long & long_cnt==MAX_LONG)).
- busy[0] is constant 0; never set.
- Scoreboard: on fire & id_long & id_rd!=0, busy[id_rd] <= 1 next edge. Cleared on the edge where that MDU result is written to the RF. Same-cycle clear and new dependent check: stall still 1 that cycle (no bypass); decode proceeds next cycle.
- long_cnt: +1 on fire & id_long (including rd==0), -1 on MDU result write; both same cycle -> unchanged. Never exceeds MAX_LONG.
- Result buffer: FIFO of {rd, data}, BUF_DEPTH entries; mdu_ready = ~full. Push on mdu_valid & mdu_ready.
- Write-port arbitration (combinational, fixed priority, 1 write/cycle):
  1. wb_valid & wb_rd!=0 -> rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data. WB is never stalled.
  2. else buffer non-empty -> write head, pop.
  3. else mdu_valid & buffer empty -> write MDU result directly (fall-through, 0-cycle latency); no push.
  4. else rf_we=0, rf_rd=0, rf_wdata=0.
- wb_valid with wb_rd==0: treated as idle slot (rf_we=0), MDU may use it.
- MDU result with rd==0: consumes a slot with rf_we=0, still decrements long_cnt.
- Push and pop same cycle when full: mdu_ready is 0 (based on registered full), no push.
- Buffer pointers wrap modulo BUF_DEPTH; count bit distinguishes full/empty.
- Write latency: RF updates on following negedge; value readable by decode in the same cycle after negedge.

Decomposition:
- Package regfile_sched_pkg: XLEN, REG_IDX_W=5, REG_ZERO=0, wb_entry_t {rd[4:0], data[XLEN-1:0]}.
- One sub-module: sched_result_fifo (parameterised BUF_DEPTH FIFO of wb_entry_t, push/pop/full/empty). Scoreboard and arbiter stay in top.

Test Plan:
- Reset mid-stream: busy[5]=1, buffer 1 entry, assert rst -> same cycle id_stall=0, rf_we=0, mdu_ready=1; id_rs1=5 decode not stalled after.
- RAW: issue long op rd=7; next cycle id_rs1=7 uses_rs1 -> id_stall=1 until MDU write of x7 (rf_we=1, rf_rd=7); stall 1 on that cycle, 0 the cycle after.
- Conflict: wb_valid rd=3 data=0xAAAA and mdu_valid rd=9 data=0x5555 same cycle, buffer empty -> rf writes x3; x9 pushed; next idle cycle rf_rd=9, rf_wdata=0x5555, busy[9] clears.
- Backpressure: WB busy 4 consecutive cycles, MDU offers 3 results -> first 2 accepted, mdu_ready=0 on 3rd; drain in FIFO order after WB idles.
- Limit: issue 4 long ops (distinct rd) -> 5th long op id_stall=1; non-long with independent regs not stalled; after one MDU write, 5th issues.
- x0: long op rd=0 -> busy[0] stays 0, rs1=0 consumer not stalled; its result gives rf_we=0 and long_cnt decrements; wb_rd=0 lets buffered MDU result write that cycle.
